// File: rtl/iz_isa_pkg.sv
// iZero ISA constants shared by the instruction memory and its neighbours:
// opcodes, the halt word, the instruction width and the loader state encoding.
package iz_isa_pkg;

    // Instruction word width of the iZero core.
    localparam int INSTR_W = 32;

    // Major opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b010110;
    localparam logic [5:0] OP_JAL  = 6'b010111;
    localparam logic [5:0] OP_HALT = 6'b011000;

    // Word handed to fetch when the PC runs past the implemented memory,
    // so a runaway program stops instead of executing garbage.
    localparam logic [INSTR_W-1:0] HALT_WORD = {OP_HALT, 26'd0};

    // Loader state encoding.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_LOAD  = LOAD,
        ST_RUN   = RUN
    } mem_state_t;

    // Opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 6];
    endfunction

endpackage

// File: rtl/memoria_de_instrucoes_carregavel_ram_sp_sync.sv
// Single-clock RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is cleared so the
// fetch output starts from a known zero.
module ram_sp_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: store a word when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: register the addressed word; hold it when not reading.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memoria_de_instrucoes_carregavel.sv
// Loadable instruction memory for iZero. A streamed loader writes a program
// word by word; once complete, the fetch stage reads it through a registered
// port with a valid flag and an out-of-range guard returning HALT_WORD.
module memoria_de_instrucoes_carregavel
    import iz_isa_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    PC_WIDTH    = 26,
    parameter int                    DEPTH       = 1024,
    parameter bit                    BOOT_LOADED = 1'b0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD   = DATA_WIDTH'(iz_isa_pkg::HALT_WORD)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PC_WIDTH-1:0]         pc,
    input  logic                        fetch_en,
    output logic [DATA_WIDTH-1:0]       instrucao,
    output logic                        instr_valid,
    output logic                        addr_error,
    input  logic                        load_start,
    input  logic [$clog2(DEPTH):0]      load_len,
    input  logic                        load_valid,
    input  logic [DATA_WIDTH-1:0]       load_data,
    output logic                        load_ready,
    output logic                        load_done,
    output logic                        prog_ready
);

    // RAM address width and loader counter width (one extra bit so a
    // full-depth length fits and the counter never wraps).
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0]       DEPTH_LEN = CW'(DEPTH);
    localparam logic [CW-1:0]       CNT_ONE   = CW'(1);
    localparam logic [PC_WIDTH:0]   DEPTH_PC  = (PC_WIDTH+1)'(DEPTH);

    mem_state_t            r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [CW-1:0]         r_len, w_len_nxt;
    logic                  r_prog_ready, w_prog_ready_nxt;
    logic                  r_load_done, w_load_done_nxt;
    logic                  r_instr_valid;
    logic                  r_addr_error;

    logic                  w_start_ok;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_fetch;
    logic                  w_pc_oob;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A load request is honoured only for a length of 1..DEPTH words.
    assign w_start_ok = load_start && (load_len != '0) && (load_len <= DEPTH_LEN);
    assign w_accept   = load_valid && (r_state == ST_LOAD);
    assign w_last     = w_accept && (r_cnt == r_len - CNT_ONE);

    // Range check at full PC width so high PC bits cannot alias into the RAM.
    assign w_pc_oob   = {1'b0, pc} >= DEPTH_PC;
    assign w_fetch    = fetch_en && (r_state == ST_RUN);

    // Writes and reads are suppressed during reset; out-of-range fetches do
    // not touch the RAM since the output mux substitutes HALT_WORD.
    assign w_we = w_accept && reset;
    assign w_re = w_fetch && !w_pc_oob && reset;

    ram_sp_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (w_we),
        .i_waddr (r_cnt[AW-1:0]),
        .i_wdata (load_data),
        .i_re    (w_re),
        .i_raddr (pc[AW-1:0]),
        .o_rdata (w_rd_data)
    );

    // Next-state logic: start a load from EMPTY/RUN, count words in LOAD,
    // return to RUN on the last word.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_len_nxt        = r_len;
        w_prog_ready_nxt = r_prog_ready;
        w_load_done_nxt  = 1'b0;
        case (r_state)
            ST_EMPTY, ST_RUN: begin
                if (w_start_ok) begin
                    w_state_nxt      = ST_LOAD;
                    w_len_nxt        = load_len;
                    w_cnt_nxt        = '0;
                    w_prog_ready_nxt = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_state_nxt      = ST_RUN;
                    w_cnt_nxt        = '0;
                    w_load_done_nxt  = 1'b1;
                    w_prog_ready_nxt = 1'b1;
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt      = ST_EMPTY;
                w_cnt_nxt        = '0;
                w_prog_ready_nxt = 1'b0;
            end
        endcase
    end

    // State register; a reset that interrupts a load always lands in EMPTY
    // because the resident program is no longer trustworthy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (BOOT_LOADED && (r_state != ST_LOAD)) begin
                r_state      <= ST_RUN;
                r_prog_ready <= 1'b1;
            end else begin
                r_state      <= ST_EMPTY;
                r_prog_ready <= 1'b0;
            end
            r_cnt       <= '0;
            r_len       <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_len        <= w_len_nxt;
            r_prog_ready <= w_prog_ready_nxt;
            r_load_done  <= w_load_done_nxt;
        end
    end

    // Fetch flags: valid for one cycle after a served fetch; the range flag
    // only changes when a fetch is served so it tracks instrucao.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_instr_valid <= 1'b0;
            r_addr_error  <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch;
            if (w_fetch) begin
                r_addr_error <= w_pc_oob;
            end
        end
    end

    assign instrucao   = r_addr_error ? HALT_WORD : w_rd_data;
    assign instr_valid = r_instr_valid;
    assign addr_error  = r_addr_error;
    assign load_ready  = (r_state == ST_LOAD);
    assign load_done   = r_load_done;
    assign prog_ready  = r_prog_ready;

endmodule

// File: tb/tb_memoria_de_instrucoes_carregavel.sv
// Bench for the loadable instruction memory: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.
module tb_memoria_de_instrucoes_carregavel;

    localparam int          DW    = 32;
    localparam int          PW    = 26;
    localparam int          DEPTH = 1024;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] HALT  = 32'h6000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic [PW-1:0] pc;
    logic          fetch_en;
    logic [DW-1:0] instrucao;
    logic          instr_valid;
    logic          addr_error;
    logic          load_start;
    logic [CW-1:0] load_len;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    logic          prog_ready;

    always #5 clock = ~clock;

    memoria_de_instrucoes_carregavel #(
        .DATA_WIDTH  (DW),
        .PC_WIDTH    (PW),
        .DEPTH       (DEPTH),
        .BOOT_LOADED (1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .instrucao   (instrucao),
        .instr_valid (instr_valid),
        .addr_error  (addr_error),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .prog_ready  (prog_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a program image, a "loading" flag with a word
    // budget, and a "program resident" flag.
    logic [31:0] m_mem [DEPTH];
    bit          m_loading = 0;
    bit          m_running = 0;
    int          m_written = 0;
    int          m_target  = 0;
    logic [31:0] e_instr   = '0;
    bit          e_valid = 0, e_aerr = 0, e_done = 0, e_pready = 0;
    int          done_seen = 0;

    task automatic model_edge();
        if (!reset) begin
            m_loading = 0; m_running = 0; m_written = 0;
            e_instr = '0; e_valid = 0; e_aerr = 0; e_done = 0; e_pready = 0;
            return;
        end
        e_valid = 0;
        e_done  = 0;
        if (m_running && fetch_en) begin
            e_valid = 1;
            if (pc < DEPTH) begin
                e_instr = m_mem[pc];
                e_aerr  = 0;
            end else begin
                e_instr = HALT;
                e_aerr  = 1;
            end
        end
        if (m_loading) begin
            if (load_valid) begin
                m_mem[m_written] = load_data;
                m_written++;
                if (m_written == m_target) begin
                    m_loading = 0; m_running = 1; m_written = 0;
                    e_done = 1; e_pready = 1;
                end
            end
        end else if (load_start && load_len >= 1 && load_len <= DEPTH) begin
            m_loading = 1; m_running = 0; m_target = load_len; m_written = 0;
            e_pready = 0;
        end
    endtask

    task automatic check_all();
        chk("instrucao",   instrucao,   e_instr);
        chk("instr_valid", instr_valid, e_valid);
        chk("addr_error",  addr_error,  e_aerr);
        chk("load_ready",  load_ready,  m_loading);
        chk("load_done",   load_done,   e_done);
        chk("prog_ready",  prog_ready,  e_pready);
        if (load_done) done_seen++;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
        @(negedge clock);
    endtask

    task automatic idle();
        fetch_en = 0; load_start = 0; load_valid = 0;
    endtask

    task automatic start(input int len);
        load_start = 1; load_len = CW'(len);
        cyc();
        load_start = 0;
    endtask

    task automatic stream(input logic [31:0] w);
        load_valid = 1; load_data = w;
        cyc();
        load_valid = 0;
    endtask

    task automatic fetch(input logic [PW-1:0] a);
        fetch_en = 1; pc = a;
        cyc();
        fetch_en = 0;
    endtask

    initial begin
        reset = 0; pc = '0; load_len = '0; load_data = '0;
        idle();
        cyc(); cyc();
        reset = 1;

        // EMPTY: fetches are not served.
        fetch_en = 1; pc = '0;
        repeat (3) cyc();
        idle();

        // Three-word load with a bubble, then read back.
        done_seen = 0;
        start(3);
        stream(32'h5800_001E);
        cyc();
        stream(32'h0063_0006);
        stream(32'h6000_0000);
        cyc();
        chk("done_pulses_3w", done_seen, 1);
        chk("prog_ready_3w",  prog_ready, 1'b1);
        fetch(0); chk("pc0_word", instrucao, 32'h5800_001E);
        fetch(1); chk("pc1_word", instrucao, 32'h0063_0006);
        fetch(2); chk("pc2_word", instrucao, 32'h6000_0000);

        // Out-of-range guard.
        fetch(PW'(DEPTH));   chk("oob_depth_err", addr_error, 1'b1);
        fetch(26'h3FF_FFFF); chk("oob_max_word",  instrucao, HALT);
        fetch(1);            chk("inrange_err",   addr_error, 1'b0);

        // Illegal lengths are ignored.
        start(0);         cyc(); chk("len0_ready", load_ready, 1'b0);
        start(DEPTH + 1); cyc(); chk("lenbig_ready", load_ready, 1'b0);

        // load_start during LOAD does not change the length.
        start(2);
        stream(32'hAAAA_0001);
        start(5);
        stream(32'hAAAA_0002);
        cyc();
        chk("relaunch_ignored", prog_ready, 1'b1);

        // Reset after 2 of 5 words, then a clean 5-word load.
        done_seen = 0;
        start(5);
        stream(32'h1111_0000); stream(32'h1111_0001);
        reset = 0; cyc(); reset = 1; cyc();
        chk("abort_no_done", done_seen, 0);
        start(5);
        for (int i = 0; i < 5; i++) stream(32'h2222_0000 + i);
        for (int i = 0; i < 5; i++) fetch(PW'(i));

        // Hold with fetch_en low, then fetch and load_start together.
        fetch(3);
        repeat (3) cyc();
        chk("hold_word", instrucao, 32'h2222_0003);
        fetch_en = 1; pc = 4; load_start = 1; load_len = CW'(2);
        cyc();
        idle();
        chk("same_edge_word", instrucao, 32'h2222_0004);
        chk("same_edge_pr",   prog_ready, 1'b0);
        stream(32'h3333_0000); stream(32'h3333_0001);

        // Full-depth load, so every address holds a known word.
        start(DEPTH);
        for (int i = 0; i < DEPTH; i++) stream($urandom);
        chk("full_prog_ready", prog_ready, 1'b1);
        fetch(PW'(DEPTH - 1));

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) != 0);
            load_start = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       load_len = '0;
                1:       load_len = CW'(DEPTH + 1);
                default: load_len = CW'($urandom_range(1, 8));
            endcase
            load_valid = $urandom_range(0, 1);
            load_data  = $urandom;
            fetch_en   = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) pc = PW'($urandom_range(DEPTH, 32'h3FF_FFFF));
            else                           pc = PW'($urandom_range(0, DEPTH - 1));
            cyc();
        end
        reset = 1;
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/memoria_de_instrucoes_carregavel.md
Name: memoria_de_instrucoes_carregavel

Overview:
Parametrised, synchronous, loadable instruction memory for the iZero core, replacing the hard-wired combinational ROM. A streamed loader (UART/boot path) writes a program at run time. The fetch stage then reads it through a registered port with a valid flag and an out-of-range guard. Sits between the PC register and the decode stage; the loader side connects to the boot/IO controller.

Parameters:
DATA_WIDTH, 32, instruction word width
PC_WIDTH, 26, width of incoming PC (jump-target field width)
DEPTH, 1024, number of words implemented (power of two not required)
BOOT_LOADED, 0, 1 = reset enters RUN with prog_ready=1 (contents from synthesis init); 0 = reset enters EMPTY
HALT_WORD, 32'h6000_0000, word returned for out-of-range PC (halt opcode 6'b011000)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
pc  in  PC_WIDTH  word address to fetch
fetch_en  in  1  fetch request this cycle
instrucao  out  DATA_WIDTH  registered instruction
instr_valid  out  1  instrucao holds a fresh fetch this cycle
addr_error  out  1  last fetch had pc >= DEPTH
load_start  in  1  begin program load
load_len  in  clog2(DEPTH)+1  number of words to load
load_valid  in  1  load_data valid
load_data  in  DATA_WIDTH  program word
load_ready  out  1  memory accepts a load word
load_done  out  1  one-cycle pulse after last word is written
prog_ready  out  1  a complete program is resident

Behaviour:
- Reset (reset==0 at edge): state = BOOT_LOADED ? RUN : EMPTY; instrucao=0, instr_valid=0, addr_error=0, load_ready=0, load_done=0, prog_ready=BOOT_LOADED, word counter=0. Memory array is not cleared.
- Reset mid-load: abort load, go to EMPTY (even if BOOT_LOADED=1), prog_ready=0; partially written words remain but are not guaranteed.
- States: EMPTY, LOAD, RUN.
  - EMPTY -> LOAD on load_start with 1 <= load_len <= DEPTH.
  - RUN -> LOAD on the same condition.
  - LOAD -> RUN when the last word is accepted.
  - load_start with load_len==0 or load_len>DEPTH is ignored (state unchanged).
  - load_start while in LOAD is ignored.
- load_ready = 1 exactly when state==LOAD; it is driven from the state register, combinationally independent of load_valid.
- Accepting a word: load_valid && load_ready writes mem[cnt] = load_data at the edge and sets cnt = cnt+1.
- Load completion: when the accepted word has cnt == load_len-1 (load_len latched at start), go to RUN, pulse load_done for the following cycle, set prog_ready=1, and reset cnt to 0. No further words are written.
- Entering LOAD from RUN clears prog_ready at the same edge.
- Fetch (state RUN, fetch_en=1 at edge N):
  - instrucao = mem[pc] if pc < DEPTH, else HALT_WORD.
  - addr_error = (pc >= DEPTH), compared at full PC_WIDTH.
  - instr_valid = 1 during cycle N+1. Latency is one cycle.
- Fetch with fetch_en=0, or state != RUN: instrucao and addr_error hold their values, instr_valid=0.
- Simultaneous fetch_en and a valid load_start in RUN: the fetch is served from the old contents at that edge, then the state moves to LOAD.
- A fetch never observes a word written in the same cycle (the state excludes it).
- Load word counter width is clog2(DEPTH)+1 and never wraps; completion is by compare.

Decomposition:
- Shared package iz_isa_pkg: opcode constants (OP_HALT=6'b011000, OP_J=6'b010110, OP_JAL, OP_NOP), HALT_WORD, instruction word width, and the state encoding localparams EMPTY/LOAD/RUN.
- One sub-module, ram_sp_sync. It is a single-clock RAM, one write port, one registered read port, parametrised DATA_WIDTH/DEPTH, with no reset on the array. The top holds the FSM, counter, range check and output muxing.

Test Plan:
- BOOT_LOADED=0, release reset, fetch_en=1 pc=0 -> instr_valid stays 0, prog_ready=0, load_ready=0.
- load_start with load_len=3, then stream 0x5800001E, 0x00630006 (one idle cycle with load_valid=0 between), 0x60000000 -> load_ready high for exactly the load window, load_done pulses once the cycle after word 3, prog_ready=1; fetches of pc=0,1,2 return those words one cycle later with instr_valid=1.
- In RUN, fetch pc=DEPTH (1024) and pc=26'h3FFFFFF -> instrucao=0x60000000, addr_error=1; next fetch pc=1 -> addr_error=0.
- load_len=0 and load_len=DEPTH+1 -> no state change, load_ready stays 0; load_start during LOAD -> ignored, original length still completes.
- Reset (reset=0) after 2 of 5 words -> state EMPTY, load_ready=0, prog_ready=0, no load_done; a fresh 5-word load then completes normally.
- In RUN, fetch_en held 0 for 3 cycles -> instrucao unchanged, instr_valid=0; fetch_en and load_start together -> old word returned, then state LOAD and prog_ready=0.
